// File: rtl/uart_param_if.sv
// Processor-side and serial-pin signals of the parametrised UART, bundled so
// the core and its user agree on one set of names and directions.
interface uart_param_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic                  tx_serial;
  logic                  rx_serial;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_interrupt;
  logic                  clear_interrupt;
  logic                  parity_error;
  logic                  framing_error;
  logic                  overrun_error;

  modport slave (
    input  tx_data, tx_start, rx_serial, clear_interrupt,
    output tx_busy, tx_serial, rx_data, rx_interrupt,
           parity_error, framing_error, overrun_error
  );

  modport master (
    output tx_data, tx_start, rx_serial, clear_interrupt,
    input  tx_busy, tx_serial, rx_data, rx_interrupt,
           parity_error, framing_error, overrun_error
  );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART. Independent TX and RX engines share one
// clock and a compile-time baud divisor; each engine has its own bit timer.
// RX samples mid-bit after a half-bit delay from the detected start edge.
module uart_param #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 5208,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic       clk,
  input logic       reset,
  uart_param_if.slave bus
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY_EN != 0);
  localparam bit ODD_BIT    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                txState, txStateNext;
  logic [CNT_W-1:0]      txCnt;
  logic [3:0]            txIdx;
  logic [DATA_WIDTH-1:0] txShift;
  logic                  txParity;
  logic                  txWrap;

  assign txWrap = (txCnt == FULL_M1);

  // TX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) txState <= IDLE;
    else       txState <= txStateNext;
  end

  // TX next state: each bit ends on a timer wrap, STOP spans STOP_BITS bits
  always_comb begin
    txStateNext = txState;
    case (txState)
      IDLE:    if (bus.tx_start) txStateNext = START;
      START:   if (txWrap) txStateNext = DATA;
      DATA:    if (txWrap && txIdx == LAST_DATA) txStateNext = HAS_PARITY ? PARITY : STOP;
      PARITY:  if (txWrap) txStateNext = STOP;
      STOP:    if (txWrap && txIdx == LAST_STOP) txStateNext = IDLE;
      default: txStateNext = IDLE;
    endcase
  end

  // TX datapath: latch the word in IDLE, then shift it out LSB first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txCnt    <= '0;
      txIdx    <= '0;
      txShift  <= '0;
      txParity <= 1'b0;
    end else if (txState == IDLE) begin
      txCnt <= '0;
      txIdx <= '0;
      if (bus.tx_start) begin
        txShift  <= bus.tx_data;
        txParity <= (^bus.tx_data) ^ ODD_BIT;
      end
    end else begin
      txCnt <= txWrap ? '0 : txCnt + 1'b1;
      if (txWrap) begin
        txIdx <= (txStateNext != txState) ? 4'd0 : txIdx + 4'd1;
        if (txState == DATA) txShift <= txShift >> 1;
      end
    end
  end

  // TX line level and busy flag decoded straight from the registered state
  always_comb begin
    bus.tx_serial = 1'b1;
    case (txState)
      START:   bus.tx_serial = 1'b0;
      DATA:    bus.tx_serial = txShift[0];
      PARITY:  bus.tx_serial = txParity;
      default: bus.tx_serial = 1'b1;
    endcase
    bus.tx_busy = (txState != IDLE);
  end

  // ---------------- receiver ----------------
  state_t                rxState, rxStateNext;
  logic                  rxSync1, rxSync2, rxPrev;
  logic [CNT_W-1:0]      rxCnt;
  logic [3:0]            rxIdx;
  logic [DATA_WIDTH-1:0] rxShift;
  logic                  rxParErr;
  logic                  rxTick;
  logic                  frameDone;

  assign rxTick    = (rxState == START) ? (rxCnt == HALF_M1) : (rxCnt == FULL_M1);
  assign frameDone = (rxState == STOP) && rxTick;

  // Two-flop synchroniser plus one history flop for start-edge detection;
  // they reset to the idle-high line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxPrev  <= 1'b1;
    end else begin
      rxSync1 <= bus.rx_serial;
      rxSync2 <= rxSync1;
      rxPrev  <= rxSync2;
    end
  end

  // RX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rxState <= IDLE;
    else       rxState <= rxStateNext;
  end

  // RX next state: a high start-bit sample is a glitch; leave after the first stop sample
  always_comb begin
    rxStateNext = rxState;
    case (rxState)
      IDLE:    if (rxPrev && !rxSync2) rxStateNext = START;
      START:   if (rxTick) rxStateNext = rxSync2 ? IDLE : DATA;
      DATA:    if (rxTick && rxIdx == LAST_DATA) rxStateNext = HAS_PARITY ? PARITY : STOP;
      PARITY:  if (rxTick) rxStateNext = STOP;
      STOP:    if (rxTick) rxStateNext = IDLE;
      default: rxStateNext = IDLE;
    endcase
  end

  // RX datapath: bit timer, LSB-first shift register and parity check
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxCnt    <= '0;
      rxIdx    <= '0;
      rxShift  <= '0;
      rxParErr <= 1'b0;
    end else if (rxState == IDLE) begin
      rxCnt    <= '0;
      rxIdx    <= '0;
      rxParErr <= 1'b0;
    end else begin
      rxCnt <= rxTick ? '0 : rxCnt + 1'b1;
      if (rxTick && rxState == DATA) begin
        rxShift <= {rxSync2, rxShift[DATA_WIDTH-1:1]};
        rxIdx   <= rxIdx + 4'd1;
      end
      if (rxTick && rxState == PARITY)
        rxParErr <= rxSync2 ^ (^rxShift) ^ ODD_BIT;
    end
  end

  // Frame completion updates data and status; completion beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rx_data       <= '0;
      bus.rx_interrupt  <= 1'b0;
      bus.parity_error  <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.overrun_error <= 1'b0;
    end else if (frameDone) begin
      bus.rx_data       <= rxShift;
      bus.parity_error  <= rxParErr;
      bus.framing_error <= ~rxSync2;
      bus.rx_interrupt  <= 1'b1;
      bus.overrun_error <= bus.clear_interrupt ? 1'b0
                           : (bus.overrun_error | bus.rx_interrupt);
    end else if (bus.clear_interrupt) begin
      bus.rx_interrupt  <= 1'b0;
      bus.overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: one instance with 8 data bits, even
// parity and one stop bit, a second with 7 data bits, no parity, two stop
// bits in permanent loopback. Both run at BAUD_DIV=4.
module tb_uart_param;

  logic clk = 1'b0;
  logic reset;
  logic loopA;
  logic rxDriveA;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  uart_param_if #(.DATA_WIDTH(8)) ifA();
  uart_param_if #(.DATA_WIDTH(7)) ifB();

  assign ifA.rx_serial = loopA ? ifA.tx_serial : rxDriveA;
  assign ifB.rx_serial = ifB.tx_serial;

  uart_param #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dutA (.clk(clk), .reset(reset), .bus(ifA));

  uart_param #(.DATA_WIDTH(7), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dutB (.clk(clk), .reset(reset), .bus(ifB));

  typedef struct {
    logic [7:0]  data;
    logic [10:0] bits;
  } txVec_t;

  typedef struct {
    logic [7:0] data;
    logic       flipPar;
    logic       stopVal;
    logic [7:0] expData;
    logic       expPar;
    logic       expFrm;
  } rxVec_t;

  txVec_t txVecs[5];
  rxVec_t rxVecs[6];

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one frame onto instance A's RX line, then 4 idle clocks
  task automatic applyStimulus(input logic [7:0] d, input logic flipPar, input logic stopVal);
    logic [10:0] f;
    f = {stopVal, (^d) ^ flipPar, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rxDriveA = f[i];
      repeat (4) @(negedge clk);
    end
    rxDriveA = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Pulse tx_start on A and record tx_serial on every clock while busy
  task automatic txFrameA(input logic [7:0] d, output int cnt, output logic [63:0] s);
    @(negedge clk);
    ifA.tx_data  = d;
    ifA.tx_start = 1'b1;
    @(negedge clk);
    ifA.tx_start = 1'b0;
    cnt = 0;
    s   = '0;
    while (ifA.tx_busy && cnt < 200) begin
      if (cnt < 64) s[cnt] = ifA.tx_serial;
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic waitRxA();
    for (int i = 0; i < 100 && !ifA.rx_interrupt; i++) @(negedge clk);
  endtask

  task automatic clearA();
    @(negedge clk);
    ifA.clear_interrupt = 1'b1;
    @(negedge clk);
    ifA.clear_interrupt = 1'b0;
  endtask

  // Each frame bit repeated for the 4 clocks of one bit period
  function automatic logic [63:0] expand(input logic [10:0] v, input int nbits);
    logic [63:0] e;
    e = '0;
    for (int j = 0; j < nbits; j++)
      for (int r = 0; r < 4; r++) e[4*j + r] = v[j];
    return e;
  endfunction

  int          busyCnt;
  int          gap;
  logic [63:0] samples;

  // Main test sequence
  initial begin
    checks = 0;
    errors = 0;
    txVecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    txVecs[1] = '{8'h5A, 11'b1_0_01011010_0};
    txVecs[2] = '{8'h01, 11'b1_1_00000001_0};
    txVecs[3] = '{8'hFF, 11'b1_0_11111111_0};
    txVecs[4] = '{8'h07, 11'b1_1_00000111_0};
    rxVecs[0] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    rxVecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    rxVecs[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    rxVecs[3] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    rxVecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
    rxVecs[5] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

    reset = 1'b1;
    loopA = 1'b0;
    rxDriveA = 1'b1;
    ifA.tx_data = '0;
    ifA.tx_start = 1'b0;
    ifA.clear_interrupt = 1'b0;
    ifB.tx_data = '0;
    ifB.tx_start = 1'b0;
    ifB.clear_interrupt = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetTxSerial", ifA.tx_serial, 1);
    checkOutput("resetTxBusy", ifA.tx_busy, 0);
    checkOutput("resetRxInt", ifA.rx_interrupt, 0);
    checkOutput("resetRxData", ifA.rx_data, 0);
    checkOutput("resetErrFlags", {ifA.parity_error, ifA.framing_error, ifA.overrun_error}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] TX frame vectors");
    for (int k = 0; k < 5; k++) begin
      txFrameA(txVecs[k].data, busyCnt, samples);
      checkOutput($sformatf("txBusyLen[%0d]", k), 64'(busyCnt), 44);
      checkOutput($sformatf("txBits[%0d]", k), samples, expand(txVecs[k].bits, 11));
    end

    $display("[TB] loopback 0x3C");
    loopA = 1'b1;
    txFrameA(8'h3C, busyCnt, samples);
    waitRxA();
    checkOutput("loopRxInt", ifA.rx_interrupt, 1);
    checkOutput("loopRxData", ifA.rx_data, 8'h3C);
    checkOutput("loopFlags", {ifA.parity_error, ifA.framing_error}, 0);
    clearA();
    checkOutput("loopClearInt", ifA.rx_interrupt, 0);
    loopA = 1'b0;

    $display("[TB] RX frame vectors");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(rxVecs[k].data, rxVecs[k].flipPar, rxVecs[k].stopVal);
      waitRxA();
      checkOutput($sformatf("rxInt[%0d]", k), ifA.rx_interrupt, 1);
      checkOutput($sformatf("rxData[%0d]", k), ifA.rx_data, rxVecs[k].expData);
      checkOutput($sformatf("rxParErr[%0d]", k), ifA.parity_error, rxVecs[k].expPar);
      checkOutput($sformatf("rxFrmErr[%0d]", k), ifA.framing_error, rxVecs[k].expFrm);
      clearA();
      checkOutput($sformatf("rxCleared[%0d]", k), ifA.rx_interrupt, 0);
      checkOutput($sformatf("rxParKept[%0d]", k), ifA.parity_error, rxVecs[k].expPar);
    end

    $display("[TB] glitch then overrun");
    @(negedge clk);
    rxDriveA = 1'b0;
    @(negedge clk);
    rxDriveA = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitchNoInt", ifA.rx_interrupt, 0);
    applyStimulus(8'h11, 1'b0, 1'b1);
    waitRxA();
    checkOutput("ovrFirstData", ifA.rx_data, 8'h11);
    checkOutput("ovrFirstFlag", ifA.overrun_error, 0);
    applyStimulus(8'h22, 1'b0, 1'b1);
    checkOutput("ovrSecondData", ifA.rx_data, 8'h22);
    checkOutput("ovrFlag", ifA.overrun_error, 1);
    checkOutput("ovrRxInt", ifA.rx_interrupt, 1);

    $display("[TB] reset mid-frame");
    fork
      applyStimulus(8'hC3, 1'b0, 1'b1);
      begin
        repeat (9) @(negedge clk);
        ifA.tx_data  = 8'hE7;
        ifA.tx_start = 1'b1;
        @(negedge clk);
        ifA.tx_start = 1'b0;
        repeat (17) @(negedge clk);
        checkOutput("preResetBusy", ifA.tx_busy, 1);
        reset = 1'b1;
        #1;
        checkOutput("midResetTxSerial", ifA.tx_serial, 1);
        checkOutput("midResetTxBusy", ifA.tx_busy, 0);
        checkOutput("midResetRxInt", ifA.rx_interrupt, 0);
        checkOutput("midResetOvr", ifA.overrun_error, 0);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    txFrameA(8'h5A, busyCnt, samples);
    checkOutput("postResetBusyLen", 64'(busyCnt), 44);
    checkOutput("postResetBits", samples, expand(11'b1_0_01011010_0, 11));
    clearA();
    applyStimulus(8'h33, 1'b0, 1'b1);
    applyStimulus(8'h44, 1'b0, 1'b1);
    checkOutput("ovr2Flag", ifA.overrun_error, 1);
    clearA();
    checkOutput("ovr2Cleared", ifA.overrun_error, 0);
    checkOutput("ovr2IntCleared", ifA.rx_interrupt, 0);

    $display("[TB] 7N2 instance");
    @(negedge clk);
    ifB.tx_data  = 7'h55;
    ifB.tx_start = 1'b1;
    @(negedge clk);
    ifB.tx_start = 1'b0;
    busyCnt = 0;
    samples = '0;
    while (ifB.tx_busy && busyCnt < 200) begin
      if (busyCnt < 64) samples[busyCnt] = ifB.tx_serial;
      busyCnt++;
      @(negedge clk);
    end
    checkOutput("bBusyLen", 64'(busyCnt), 40);
    checkOutput("bBits", samples, expand(11'b0_11_1010101_0, 10));
    for (int i = 0; i < 100 && !ifB.rx_interrupt; i++) @(negedge clk);
    checkOutput("bRxInt", ifB.rx_interrupt, 1);
    checkOutput("bRxData", ifB.rx_data, 7'h55);
    checkOutput("bFlags", {ifB.parity_error, ifB.framing_error}, 0);

    @(negedge clk);
    ifB.tx_data  = 7'h2A;
    ifB.tx_start = 1'b1;
    for (int i = 0; i < 10 && !ifB.tx_busy; i++) @(negedge clk);
    for (int i = 0; i < 100 && ifB.tx_busy; i++) @(negedge clk);
    gap = 0;
    for (int i = 0; i < 10 && !ifB.tx_busy; i++) begin
      gap++;
      @(negedge clk);
    end
    ifB.tx_start = 1'b0;
    checkOutput("bBackToBackGap", 64'(gap), 1);
    for (int i = 0; i < 100 && ifB.tx_busy; i++) @(negedge clk);
    checkOutput("bIdleAfter", ifB.tx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
Parametrised full-duplex UART: one TX and one RX engine sharing a single clock and a compile-time baud divisor. Configurable data width, parity mode and stop-bit count. Adds a TX busy handshake, a sticky RX interrupt with clear, and parity, framing and overrun error reporting. Sits between the processor-side register interface and the board serial pins; it is the drop-in successor to the fixed 8-bit UART.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
BAUD_DIV, 5208, clocks per bit (>=4); 5208 gives 9600 baud at 50 MHz
PARITY_EN, 1, 1 = parity bit present after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, stop bits transmitted and checked (1 or 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tx_data  in  DATA_WIDTH  word to transmit
tx_start  in  1  transmit request, sampled only when tx_busy=0
tx_busy  out  1  TX frame in progress
tx_serial  out  1  serial TX line, idle high
rx_serial  in  1  serial RX line, asynchronous
rx_data  out  DATA_WIDTH  last received word
rx_interrupt  out  1  sticky frame-received flag
clear_interrupt  in  1  clears rx_interrupt and overrun_error
parity_error  out  1  parity mismatch on last frame
framing_error  out  1  stop bit(s) low on last frame
overrun_error  out  1  frame completed while rx_interrupt was still set (sticky)

Behaviour:
- Reset, async: tx_serial=1; all other outputs 0; both FSMs go to IDLE; all counters are cleared. Reset mid-frame aborts the frame, with no partial update.
- Bit timer: per-engine counter from 0 to BAUD_DIV-1; each wrap ends the current bit.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
  - tx_start=1 in IDLE latches tx_data; tx_busy and tx_serial=0 follow on the next edge.
  - Data is sent LSB first. Each bit is held exactly BAUD_DIV clocks.
  - STOP drives 1 for STOP_BITS*BAUD_DIV clocks. tx_busy falls as STOP ends.
  - tx_busy is high for (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*BAUD_DIV clocks.
  - tx_start while busy is ignored (not queued). tx_start held high starts back-to-back frames, with 1 idle clock between them.
- RX input: 2-flop synchroniser (2-clock latency); the FSM sees only the synchronised signal.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - A high-to-low transition in IDLE enters START.
  - At BAUD_DIV/2 clocks (integer division) the line is resampled. If high, it is a glitch: return to IDLE with no flags changed.
  - Subsequent samples are taken every BAUD_DIV clocks, so each lands mid-bit. Data is shifted in LSB first.
  - Parity is computed as XOR of the data bits, XOR PARITY_ODD.
  - Only the first stop bit is sampled. The FSM returns to IDLE right after that sample, so a new start can be accepted during a second stop bit.
- Frame completion (cycle of the first stop-bit sample):
  - rx_data is loaded.
  - parity_error and framing_error are overwritten with this frame's results.
  - rx_interrupt is set. If rx_interrupt was already 1 and not being cleared this cycle, overrun_error is set. Data is always overwritten.
  - A frame with errors still loads data and sets the interrupt.
- clear_interrupt: clears rx_interrupt and overrun_error on the next edge. It does not touch the parity or framing flags. If clear and completion occur in the same cycle, the set wins: rx_interrupt=1 and overrun is not flagged.
- TX and RX are fully independent; loopback (tx_serial to rx_serial) must work.

Test Plan:
1. BAUD_DIV=4, DATA_WIDTH=8, even parity, 1 stop; pulse tx_start with tx_data=0xA5 -> tx_serial sequence is 0,1,0,1,0,0,1,0,1,0(parity),1, 4 clocks per bit; tx_busy high exactly 44 clocks.
2. Loopback of 0x3C -> rx_interrupt=1, rx_data=0x3C, parity_error=0, framing_error=0. Then pulse clear_interrupt -> rx_interrupt=0 next edge.
3. Drive a 0xA5 frame with parity bit=1 -> parity_error=1, rx_data=0xA5, rx_interrupt=1. Next frame with stop bit=0 -> framing_error=1, parity_error=0.
4. rx_serial low for 1 clock, then high -> no rx_interrupt, FSM back in IDLE. Then send two frames, 0x11 then 0x22, without clearing -> rx_data=0x22, overrun_error=1.
5. Assert reset during TX data bit 3 and RX data bit 5 -> tx_serial=1, tx_busy=0, rx_interrupt=0 immediately. A next tx_start of 0x5A transmits a correct full frame.
6. DATA_WIDTH=7, PARITY_EN=0, STOP_BITS=2, BAUD_DIV=4 -> tx_busy high 40 clocks; loopback of 0x55 gives rx_data=0x55.
